// File: rtl/intc_pkg.sv
// intc_pkg: state encoding, memory-stage selector codes and defaults
// shared by the interrupt controller files.
package intc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    PUSH_LO  = 3'd2,
    PUSH_HI  = 3'd3,
    PUSH_FLG = 3'd4,
    JUMP     = 3'd5,
    ACTIVE   = 3'd6,
    RESTORE  = 3'd7
  } intc_state_e;

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_PC_LO = 2'b01;
  localparam logic [1:0] SEL_PC_HI = 2'b10;
  localparam logic [1:0] SEL_FLAGS = 2'b11;

  localparam logic [31:0] DEF_VECTOR_ADDR = 32'd2;

endpackage

// File: rtl/intc_edge_latch.sv
// intc_edge_latch: rising-edge detect on int_req and the pending flag.
// Clear has priority, so an edge arriving as pending is consumed merges.
module intc_edge_latch
  import intc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic int_req_i,
  input  logic clr_i,
  output logic pending_o
);

  logic req_q;
  logic pend_q;
  logic pend_d;
  logic evt;

  assign evt = int_req_i & ~req_q;

  always_comb begin
    pend_d = pend_q;
    if (clr_i)
      pend_d = 1'b0;
    else if (evt)
      pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      req_q  <= int_req_i;
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: drain, push PC/flags, redirect, await RTI.
// Define INTC_MASK_EN to add the int_enable gate on IDLE->DRAIN.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int              PC_W         = 32,
  parameter int              FLAG_W       = 4,
  parameter logic [PC_W-1:0] VECTOR_ADDR  = PC_W'(DEF_VECTOR_ADDR),
  parameter int              DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              int_req,
  input  logic              pipe_stall,
  input  logic              ret_int,
`ifdef INTC_MASK_EN
  input  logic              int_enable,
`endif
  input  logic [PC_W-1:0]   pc_in,
  input  logic [FLAG_W-1:0] flags_in,
  output logic              int_stall,
  output logic              int_flush,
  output logic              int_mem_selector1,
  output logic              int_mem_selector2,
  output logic              int_push,
  output logic              int_pc_sel,
  output logic [PC_W-1:0]   int_vector_addr,
  output logic [PC_W-1:0]   saved_pc,
  output logic [FLAG_W-1:0] saved_flags,
  output logic              restore_flags,
  output logic              int_active
);

  localparam int CNT_W =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  intc_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PC_W-1:0]   spc_q, spc_d;
  logic [FLAG_W-1:0] sfl_q, sfl_d;
  logic              pending;
  logic              clr;
  logic              en;
  logic [1:0]        sel;

`ifdef INTC_MASK_EN
  assign en = int_enable;
`else
  assign en = 1'b1;
`endif

  intc_edge_latch u_edge (
    .clk       (clk),
    .reset     (reset),
    .int_req_i (int_req),
    .clr_i     (clr),
    .pending_o (pending)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      spc_q   <= '0;
      sfl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      spc_q   <= spc_d;
      sfl_q   <= sfl_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    spc_d         = spc_q;
    sfl_d         = sfl_q;
    clr           = 1'b0;
    sel           = SEL_NONE;
    int_stall     = 1'b0;
    int_flush     = 1'b0;
    int_push      = 1'b0;
    int_pc_sel    = 1'b0;
    int_active    = 1'b0;
    restore_flags = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending && en) begin
          state_d = DRAIN;
          clr     = 1'b1;
          spc_d   = pc_in;
          sfl_d   = flags_in;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        int_stall = 1'b1;
        int_flush = 1'b1;
        if (cnt_q == '0)
          state_d = PUSH_LO;
        else
          cnt_d = cnt_q - 1'b1;
      end
      // A pipeline stall freezes the push but keeps the data select.
      PUSH_LO: begin
        sel       = SEL_PC_LO;
        int_stall = 1'b1;
        int_push  = ~pipe_stall;
        if (!pipe_stall) state_d = PUSH_HI;
      end
      PUSH_HI: begin
        sel       = SEL_PC_HI;
        int_stall = 1'b1;
        int_push  = ~pipe_stall;
        if (!pipe_stall) state_d = PUSH_FLG;
      end
      PUSH_FLG: begin
        sel       = SEL_FLAGS;
        int_stall = 1'b1;
        int_push  = ~pipe_stall;
        if (!pipe_stall) state_d = JUMP;
      end
      JUMP: begin
        int_pc_sel = 1'b1;
        state_d    = ACTIVE;
      end
      ACTIVE: begin
        int_active = 1'b1;
        if (ret_int) state_d = RESTORE;
      end
      RESTORE: begin
        restore_flags = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign int_mem_selector1 = sel[0];
  assign int_mem_selector2 = sel[1];
  assign int_vector_addr   = VECTOR_ADDR;
  assign saved_pc          = spc_q;
  assign saved_flags       = sfl_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed per-cycle vector table plus
// hand-written sequences for held level, nesting and masking.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        int_req;
  logic        pipe_stall;
  logic        ret_int;
  logic [31:0] pc_in;
  logic [3:0]  flags_in;
  logic        int_stall, int_flush;
  logic        int_mem_selector1, int_mem_selector2;
  logic        int_push, int_pc_sel;
  logic [31:0] int_vector_addr, saved_pc;
  logic [3:0]  saved_flags;
  logic        restore_flags, int_active;
`ifdef INTC_MASK_EN
  logic        int_enable = 1'b1;
`endif

  interrupt_controller dut (
    .clk               (clk),
    .reset             (reset),
    .int_req           (int_req),
    .pipe_stall        (pipe_stall),
    .ret_int           (ret_int),
`ifdef INTC_MASK_EN
    .int_enable        (int_enable),
`endif
    .pc_in             (pc_in),
    .flags_in          (flags_in),
    .int_stall         (int_stall),
    .int_flush         (int_flush),
    .int_mem_selector1 (int_mem_selector1),
    .int_mem_selector2 (int_mem_selector2),
    .int_push          (int_push),
    .int_pc_sel        (int_pc_sel),
    .int_vector_addr   (int_vector_addr),
    .saved_pc          (saved_pc),
    .saved_flags       (saved_flags),
    .restore_flags     (restore_flags),
    .int_active        (int_active)
  );

  always #5 clk = ~clk;

  // {stall, flush, sel2, sel1, push, pc_sel, active, restore}
  localparam logic [7:0] O_IDLE  = 8'b0000_0000;
  localparam logic [7:0] O_DRAIN = 8'b1100_0000;
  localparam logic [7:0] O_PLO   = 8'b1001_1000;
  localparam logic [7:0] O_PHI   = 8'b1010_1000;
  localparam logic [7:0] O_PHI_S = 8'b1010_0000;
  localparam logic [7:0] O_PFL   = 8'b1011_1000;
  localparam logic [7:0] O_JMP   = 8'b0000_0100;
  localparam logic [7:0] O_ACT   = 8'b0000_0010;
  localparam logic [7:0] O_RST   = 8'b0000_0001;

  typedef struct {
    int          rep;
    bit          rst, req, stl, ret;
    logic [31:0] pc;
    logic [3:0]  fl;
    logic [7:0]  eo;
    logic [31:0] spc;
    logic [3:0]  sfl;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(int rep, bit rst, bit req, bit stl, bit ret,
                     logic [31:0] pc, logic [3:0] fl, logic [7:0] eo,
                     logic [31:0] spc, logic [3:0] sfl);
    vec_t v;
    v.rep = rep; v.rst = rst; v.req = req; v.stl = stl; v.ret = ret;
    v.pc = pc; v.fl = fl; v.eo = eo; v.spc = spc; v.sfl = sfl;
    tbl.push_back(v);
  endtask

  task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] obs();
    return {int_stall, int_flush, int_mem_selector2, int_mem_selector1,
            int_push, int_pc_sel, int_active, restore_flags};
  endfunction

  task automatic wait_active();
    bit ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk); #1;
      ok = int_active;
    end
    chk("wait_active", 96'(ok), 96'd1);
  endtask

  task automatic finish_service();
    wait_active();
    @(negedge clk); ret_int = 1'b1; #1;
    @(negedge clk); ret_int = 1'b0; #1;
    chk("finish_restore", 96'(restore_flags), 96'd1);
    @(negedge clk); #1;
    chk("finish_idle", 96'(obs()), 96'(O_IDLE));
  endtask

  initial begin
    int n;
    int stalls;
    reset = 1'b1; int_req = 1'b0; pipe_stall = 1'b0; ret_int = 1'b0;
    pc_in = '0; flags_in = '0;

    // rep rst req stl ret  pc  fl  expected  spc  sfl
    add(5, 0, 0, 0, 0, 32'h40, 4'ha, O_IDLE,  32'h0,  4'h0);
    add(1, 0, 1, 0, 0, 32'h40, 4'ha, O_IDLE,  32'h0,  4'h0);
    add(1, 0, 0, 0, 0, 32'h40, 4'ha, O_IDLE,  32'h0,  4'h0);
    add(3, 0, 0, 0, 0, 32'h40, 4'ha, O_DRAIN, 32'h40, 4'ha);
    add(1, 0, 0, 0, 0, 32'h40, 4'ha, O_PLO,   32'h40, 4'ha);
    add(1, 0, 0, 0, 0, 32'h40, 4'ha, O_PHI,   32'h40, 4'ha);
    add(1, 0, 0, 0, 0, 32'h40, 4'ha, O_PFL,   32'h40, 4'ha);
    add(1, 0, 0, 0, 0, 32'h40, 4'ha, O_JMP,   32'h40, 4'ha);
    add(1, 0, 0, 0, 0, 32'h40, 4'ha, O_ACT,   32'h40, 4'ha);
    add(1, 0, 0, 0, 1, 32'h40, 4'ha, O_ACT,   32'h40, 4'ha);
    add(1, 0, 0, 0, 0, 32'h40, 4'ha, O_RST,   32'h40, 4'ha);
    add(1, 0, 0, 0, 0, 32'h40, 4'ha, O_IDLE,  32'h40, 4'ha);
    add(1, 0, 1, 0, 0, 32'h80, 4'h5, O_IDLE,  32'h40, 4'ha);
    add(1, 0, 0, 0, 0, 32'h80, 4'h5, O_IDLE,  32'h40, 4'ha);
    add(1, 0, 0, 0, 0, 32'h80, 4'h5, O_DRAIN, 32'h80, 4'h5);
    add(1, 0, 0, 1, 0, 32'h80, 4'h5, O_DRAIN, 32'h80, 4'h5);
    add(1, 0, 0, 0, 0, 32'h80, 4'h5, O_DRAIN, 32'h80, 4'h5);
    add(1, 0, 0, 0, 0, 32'h80, 4'h5, O_PLO,   32'h80, 4'h5);
    add(2, 0, 0, 1, 0, 32'h80, 4'h5, O_PHI_S, 32'h80, 4'h5);
    add(1, 0, 0, 0, 0, 32'h80, 4'h5, O_PHI,   32'h80, 4'h5);
    add(1, 0, 0, 0, 0, 32'h80, 4'h5, O_PFL,   32'h80, 4'h5);
    add(1, 0, 0, 0, 0, 32'h80, 4'h5, O_JMP,   32'h80, 4'h5);
    add(1, 0, 0, 0, 1, 32'h80, 4'h5, O_ACT,   32'h80, 4'h5);
    add(1, 0, 0, 0, 0, 32'h80, 4'h5, O_RST,   32'h80, 4'h5);
    add(1, 0, 0, 0, 1, 32'h80, 4'h5, O_IDLE,  32'h80, 4'h5);
    add(1, 0, 0, 0, 0, 32'h80, 4'h5, O_IDLE,  32'h80, 4'h5);
    add(1, 0, 1, 0, 0, 32'h80, 4'h5, O_IDLE,  32'h80, 4'h5);
    add(1, 0, 0, 0, 0, 32'h80, 4'h5, O_IDLE,  32'h80, 4'h5);
    add(3, 0, 0, 0, 0, 32'h80, 4'h5, O_DRAIN, 32'h80, 4'h5);
    add(1, 1, 0, 0, 0, 32'h80, 4'h5, O_PLO,   32'h80, 4'h5);
    add(3, 0, 0, 0, 0, 32'h80, 4'h5, O_IDLE,  32'h0,  4'h0);

    @(negedge clk); #1;
    chk("reset_outputs", 96'(obs()), 96'(O_IDLE));
    chk("reset_saved", {int_vector_addr, saved_pc, 28'd0, saved_flags},
        {32'd2, 32'd0, 32'd0});

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        @(negedge clk);
        reset = tbl[i].rst; int_req = tbl[i].req;
        pipe_stall = tbl[i].stl; ret_int = tbl[i].ret;
        pc_in = tbl[i].pc; flags_in = tbl[i].fl;
        #1;
        chk($sformatf("row%0d_out", i), 96'(obs()), 96'(tbl[i].eo));
        chk($sformatf("row%0d_saved", i),
            {int_vector_addr, saved_pc, 28'd0, saved_flags},
            {32'd2, tbl[i].spc, 28'd0, tbl[i].sfl});
      end
    end
    reset = 1'b0; pipe_stall = 1'b0; ret_int = 1'b0;

    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      int_req = (k < 20);
      ret_int = int_active;
      #1;
      if (int_push && int_mem_selector1 && !int_mem_selector2) n++;
    end
    ret_int = 1'b0;
    chk("held_level_services", 96'(n), 96'd1);
    chk("held_level_idle", 96'(obs()), 96'(O_IDLE));

    pc_in = 32'h100; flags_in = 4'b0011;
    @(negedge clk); int_req = 1'b1; #1;
    @(negedge clk); int_req = 1'b0; #1;
    wait_active();
    @(negedge clk);
    pc_in = 32'h200; flags_in = 4'b1100; int_req = 1'b1; #1;
    stalls = int_stall;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); int_req = 1'b0; #1;
      stalls += int_stall;
    end
    chk("nested_no_stall", 96'(stalls), 96'd0);
    @(negedge clk); ret_int = 1'b1; #1;
    @(negedge clk); ret_int = 1'b0; #1;
    chk("nested_restore", {restore_flags, saved_flags}, 96'b1_0011);
    @(negedge clk); #1;
    chk("nested_idle", {obs(), saved_pc}, {O_IDLE, 32'h100});
    @(negedge clk); #1;
    chk("nested_drain", {obs(), saved_pc, saved_flags},
        {O_DRAIN, 32'h200, 4'b1100});
    finish_service();

`ifdef INTC_MASK_EN
    @(negedge clk); int_enable = 1'b0; int_req = 1'b1; #1;
    stalls = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); int_req = 1'b0; #1;
      stalls += int_stall;
    end
    chk("mask_no_drain", 96'(stalls), 96'd0);
    @(negedge clk); int_enable = 1'b1; #1;
    chk("mask_still_idle", 96'(obs()), 96'(O_IDLE));
    @(negedge clk); #1;
    chk("mask_drain", 96'(obs()), 96'(O_DRAIN));
    @(negedge clk); int_enable = 1'b0; #1;
    chk("mask_drain_cont", 96'(obs()), 96'(O_DRAIN));
    finish_service();
    int_enable = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
